// File: rtl/mult_booth_ctrl.sv
// Sequential radix-2 Booth multiplier controller that borrows the shared 32-bit adder.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips the iterations and finishes in one cycle.
module mult_booth_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] adder_a,
   output logic [WIDTH-1:0] adder_b,
   output logic             adder_cin,
   input  logic [WIDTH-1:0] adder_sum,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);
   localparam int MSB = WIDTH - 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d, acc_q, acc_d, q_q, q_d, res_q, res_d;
   logic             q1_q, q1_d, exc_q, exc_d, ovf;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      m_d            = m_q;
      acc_d          = acc_q;
      q_d            = q_q;
      q1_d           = q1_q;
      cnt_d          = cnt_q;
      res_d          = res_q;
      exc_d          = exc_q;
      adder_a        = '0;
      adder_b        = '0;
      adder_cin      = 1'b0;
      ovf            = 1'b0;
      busy           = 1'b0;
      data_resultRDY = (state_q == S_DONE);
      case (state_q)
         S_RUN: begin
            busy    = 1'b1;
            adder_a = acc_q;
            case ({q_q[0], q1_q})
               2'b01:   adder_b = m_q;
               2'b10: begin
                  adder_b   = ~m_q;
                  adder_cin = 1'b1;
               end
               default: adder_b = '0;
            endcase
            // ACC is really WIDTH+1 bits wide; a signed overflow of the add flips the true sign.
            ovf = (adder_a[MSB] == adder_b[MSB]) & (adder_sum[MSB] != adder_a[MSB]);
            {acc_d, q_d, q1_d} = {adder_sum[MSB] ^ ovf, adder_sum, q_q};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_DONE;
               res_d   = q_d;
               exc_d   = ~(acc_d == {WIDTH{q_d[MSB]}});
            end
         end
         default: begin
            state_d = S_IDLE;
            if (ctrl_MULT) begin
               m_d     = data_operandA;
               acc_d   = '0;
               q_d     = data_operandB;
               q1_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_RUN;
`ifdef MULT_ZERO_BYPASS_EN
               if (data_operandA == '0 || data_operandB == '0) begin
                  state_d = S_DONE;
                  res_d   = '0;
                  exc_d   = 1'b0;
               end
`else
`endif
            end
         end
      endcase
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Self-checking bench for mult_booth_ctrl; the bench itself plays the shared adder and
// compares against 64-bit signed multiplication.
module tb_mult_booth_ctrl;
   logic        clock = 1'b0, reset = 1'b1, ctrl_MULT = 1'b0;
   logic [31:0] data_operandA = '0, data_operandB = '0;
   logic [31:0] adder_a, adder_b, adder_sum, data_result;
   logic        adder_cin, data_exception, data_resultRDY, busy;
   int n_tests = 0, n_fail = 0;

   always #5 clock = ~clock;
   assign adder_sum = adder_a + adder_b + {31'b0, adder_cin};

   mult_booth_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin), .adder_sum(adder_sum),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY), .busy(busy));

   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic exc);
      longint p;
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (p != longint'($signed(p[31:0])));
   endfunction

   function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_BYPASS_EN
      if (a == 0 || b == 0) return 1;
`endif
      return 33;
   endfunction

   // Called at a negedge; returns at the negedge of cycle 1 after the start edge.
   task automatic start(input logic [31:0] a, input logic [31:0] b);
      data_operandA = a; data_operandB = b; ctrl_MULT = 1'b1;
      @(negedge clock);
      ctrl_MULT = 1'b0;
   endtask

   // Waits for RDY, checking busy and idle adder outputs each cycle; poke>0 pulses ctrl_MULT mid-run.
   task automatic wait_done(input string tag, input int elat, input int poke, output int lat);
      lat = 1;
      while (!data_resultRDY && lat < 100) begin
         n_tests++;
         if (busy !== (lat < elat)) begin
            n_fail++; $display("FAIL %s busy cyc%0d: got %b want %b", tag, lat, busy, lat < elat);
         end
         if (!busy && (adder_a !== 0 || adder_b !== 0 || adder_cin !== 0)) begin
            n_fail++; $display("FAIL %s adder_idle cyc%0d: got %h %h %b want 0", tag, lat, adder_a, adder_b, adder_cin);
         end
         if (poke == lat) begin
            ctrl_MULT = 1'b1; data_operandA = $urandom; data_operandB = $urandom;
         end else ctrl_MULT = 1'b0;
         @(negedge clock);
         lat++;
      end
      ctrl_MULT = 1'b0;
      n_tests++;
      if (lat >= 100) begin
         n_fail++; $display("FAIL %s timeout: no RDY within %0d cycles", tag, lat);
      end else if (busy !== 1'b0) begin
         n_fail++; $display("FAIL %s busy_in_done: got %b want 0", tag, busy);
      end
   endtask

   task automatic run_check(input logic [31:0] a, input logic [31:0] b, input string tag, input int poke);
      logic [31:0] er; logic ee; int lat, el;
      model(a, b, er, ee);
      el = exp_lat(a, b);
      start(a, b);
      wait_done(tag, el, poke, lat);
      n_tests++;
      if (lat !== el || data_result !== er || data_exception !== ee) begin
         n_fail++;
         $display("FAIL %s %h*%h: got lat=%0d res=%h exc=%b want lat=%0d res=%h exc=%b",
                  tag, a, b, lat, data_result, data_exception, el, er, ee);
      end
      @(negedge clock);
      n_tests++;
      if (data_resultRDY !== 1'b0 || data_result !== er || data_exception !== ee) begin
         n_fail++; $display("FAIL %s rdy_pulse/hold: got rdy=%b res=%h want rdy=0 res=%h", tag, data_resultRDY, data_result, er);
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      n_tests++;
      if ({data_result, data_exception, data_resultRDY, busy, adder_a, adder_b, adder_cin} !== '0) begin
         n_fail++; $display("FAIL reset_state: got res=%h exc=%b rdy=%b busy=%b a=%h b=%h cin=%b want all 0",
                            data_result, data_exception, data_resultRDY, busy, adder_a, adder_b, adder_cin);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_directed();
      logic [31:0] ta [8] = '{32'd3, 32'hFFFFFFF9, 32'd6, 32'h80000000, 32'h00010000, 32'h7FFFFFFF, 32'h80000000, 32'd0};
      logic [31:0] tb [8] = '{32'd4, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h00010000, 32'd1, 32'h80000000, 32'd12345};
      for (int i = 0; i < 8; i++) run_check(ta[i], tb[i], "directed", 0);
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 30; i++) begin
         case (i % 5)
            0: begin a = $urandom; b = $urandom; end
            1: begin a = $urandom_range(0, 2000) - 1000; b = $urandom_range(0, 2000) - 1000; end
            2: begin a = 32'h80000000; b = $urandom; end
            3: begin a = $urandom; b = 32'h80000000 | ($urandom & 32'hF); end
            default: begin a = $urandom_range(0, 65535); b = (i % 2) ? 32'd0 : $urandom; end
         endcase
         run_check(a, b, "random", 0);
      end
   endtask

   task automatic test_ignore_midrun();
      run_check(32'd123, 32'hFFFFFF00, "midrun_poke", 10);
   endtask

   task automatic test_back_to_back();
      int lat;
      start(32'd2, 32'd3);
      wait_done("b2b_first", 33, 0, lat);
      n_tests++;
      if (lat !== 33 || data_result !== 32'd6 || data_exception !== 1'b0) begin
         n_fail++; $display("FAIL b2b_first: got lat=%0d res=%h exc=%b want lat=33 res=6 exc=0", lat, data_result, data_exception);
      end
      start(32'hFFFFFFFF, 32'hFFFFFFFF);
      n_tests++;
      if (busy !== 1'b1 || data_result !== 32'd6) begin
         n_fail++; $display("FAIL b2b_restart: got busy=%b res=%h want busy=1 res=6", busy, data_result);
      end
      wait_done("b2b_second", 33, 0, lat);
      n_tests++;
      if (lat !== 33 || data_result !== 32'd1 || data_exception !== 1'b0) begin
         n_fail++; $display("FAIL b2b_second: got lat=%0d res=%h exc=%b want lat=33 res=1 exc=0", lat, data_result, data_exception);
      end
      @(negedge clock);
   endtask

   task automatic test_reset_midrun();
      int rdy_seen = 0;
      start(32'd9, 32'd9);
      repeat (9) @(negedge clock);
      reset = 1'b1;
      #1;
      n_tests++;
      if ({data_result, data_exception, data_resultRDY, busy, adder_a, adder_b, adder_cin} !== '0) begin
         n_fail++; $display("FAIL reset_midrun: got res=%h exc=%b rdy=%b busy=%b a=%h want all 0",
                            data_result, data_exception, data_resultRDY, busy, adder_a);
      end
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (data_resultRDY || busy) rdy_seen++;
      end
      n_tests++;
      if (rdy_seen != 0) begin
         n_fail++; $display("FAIL reset_discard: got %0d active cycles want 0", rdy_seen);
      end
      run_check(32'd5, 32'd5, "after_reset", 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_midrun();
      test_back_to_back();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
